// File: rtl/spill_register_pipe.sv
// Chain of NumStages two-slot spill stages with synchronous flush and an occupancy count.
// Latency is NumStages edges at 1 beat/cycle; every stage registers both valid/data and ready.
module spill_register_pipe #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumStages = 2,
  parameter bit          Bypass    = 1'b0,
  parameter int unsigned CntWidth  = $clog2(2*NumStages+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [CntWidth-1:0]  count_o
);

  if (Bypass) begin : g_bypass
    assign valid_o = valid_i & ~flush_i;
    assign ready_o = ready_i & ~flush_i;
    assign data_o  = data_i;
    assign count_o = '0;
  end else begin : g_pipe
    // Index k is the input side of stage k; index NumStages is the block output.
    logic [NumStages:0]   s_vld;
    logic [NumStages:0]   s_rdy;
    logic [DataWidth-1:0] s_dat [NumStages+1];
    logic                 in_xfer;
    logic                 out_xfer;
    logic [CntWidth-1:0]  count_q;

    assign s_vld[0]         = valid_i & ~flush_i;
    assign s_dat[0]         = data_i;
    assign s_rdy[NumStages] = ready_i;

    for (genvar k = 0; k < NumStages; k++) begin : g_stage
      logic                 a_full, b_full;
      logic [DataWidth-1:0] a_data, b_data;
      logic                 a_fill, a_drain, b_fill, b_drain;

      assign s_rdy[k]   = ~a_full | ~b_full;
      assign s_vld[k+1] = a_full | b_full;
      assign s_dat[k+1] = b_full ? b_data : a_data;

      assign a_fill  = s_vld[k] & s_rdy[k];
      assign a_drain = a_full & ~b_full;
      assign b_fill  = a_drain & ~s_rdy[k+1];
      assign b_drain = b_full & s_rdy[k+1];

      always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
          a_full <= 1'b0;
          b_full <= 1'b0;
        end else begin
          a_full <= a_fill | (a_full & ~a_drain);
          b_full <= b_fill | (b_full & ~b_drain);
        end
      end

      // Payload registers carry no reset; the full flags qualify them.
      always_ff @(posedge clk_i) begin
        if (a_fill) a_data <= s_dat[k];
        if (b_fill) b_data <= a_data;
      end
    end

    assign ready_o  = s_rdy[0] & ~flush_i;
    assign valid_o  = s_vld[NumStages] & ~flush_i;
    assign data_o   = s_dat[NumStages];
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i)
        count_q <= '0;
      else if (in_xfer && !out_xfer)
        count_q <= count_q + CntWidth'(1);
      else if (out_xfer && !in_xfer)
        count_q <= count_q - CntWidth'(1);
    end

    assign count_o = count_q;

`ifndef SYNTHESIS
    a_stable: assert property (@(posedge clk_i)
      (valid_o && !ready_i && !flush_i && !rst_i) |=>
        (flush_i || rst_i || (valid_o && $stable(data_o))));
    a_count: assert property (@(posedge clk_i)
      32'(count_o) <= 2*NumStages);
`endif
  end

`ifndef SYNTHESIS
  a_params: assert property (@(posedge clk_i) DataWidth >= 1 && NumStages >= 1);
`endif

endmodule

// File: tb/tb_spill_register_pipe.sv
// Directed and randomised checks of spill_register_pipe against a queue scoreboard.
module tb_spill_register_pipe;
  localparam int DW = 8;
  localparam int NS = 2;
  localparam int CW = $clog2(2*NS+1);

  logic          clk = 1'b0;
  logic          rst, flush, valid_i, ready_i;
  logic [DW-1:0] data_i;
  logic          valid_o, ready_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] count_o;

  logic          b_flush, b_valid_i, b_ready_i;
  logic [DW-1:0] b_data_i;
  logic          b_valid_o, b_ready_o;
  logic [DW-1:0] b_data_o;
  logic [1:0]    b_count_o;

  int            errors = 0;
  int            checks = 0;
  int            sent;
  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  spill_register_pipe #(.DataWidth(DW), .NumStages(NS), .Bypass(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .count_o(count_o)
  );

  spill_register_pipe #(.DataWidth(DW), .NumStages(1), .Bypass(1'b1)) u_byp (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
    .count_o(b_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard the handshakes seen before the edge, then check count and hold.
  task automatic tick();
    logic          ix, ox, hold, clr;
    logic [DW-1:0] od, id;
    #1;
    ix   = valid_i && ready_o;
    ox   = valid_o && ready_i;
    od   = data_o;
    id   = data_i;
    hold = valid_o && !ready_i && !flush && !rst;
    clr  = rst || flush;
    if (ox) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL order observed=0x%0h expected=no_beat", od);
      end else begin
        chk("order", od, q[0]);
      end
    end
    @(posedge clk);
    #1;
    if (clr) q.delete();
    else begin
      if (ox && q.size() > 0) void'(q.pop_front());
      if (ix) q.push_back(id);
    end
    chk("count_vs_model", count_o, q.size());
    if (hold) begin
      chk("hold_valid", valid_o, 1);
      chk("hold_data", data_o, od);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    b_flush = 1'b0; b_valid_i = 1'b0; b_ready_i = 1'b0; b_data_i = '0;

    // Reset, then back-to-back stream 0x01..0x08
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_count", count_o, 0);
    ready_i = 1'b1; valid_i = 1'b1; data_i = 8'h01;
    tick();
    chk("lat_valid_e1", valid_o, 0);
    chk("lat_count_e1", count_o, 1);
    for (int i = 2; i <= 8; i++) begin
      data_i = 8'(i);
      tick();
      chk("stream_valid", valid_o, 1);
      chk("stream_data", data_o, i - 1);
      chk("stream_count", count_o, 2);
    end
    valid_i = 1'b0;
    tick();
    chk("tail_data", data_o, 8'h08);
    chk("tail_count", count_o, 1);
    tick();
    chk("empty_valid", valid_o, 0);
    chk("empty_count", count_o, 0);

    // Backpressure to full
    ready_i = 1'b0; valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'h10 + 8'(i);
      tick();
    end
    chk("full_ready", ready_o, 0);
    chk("full_count", count_o, 4);
    chk("full_head", data_o, 8'h10);
    data_i = 8'h14;
    tick();
    chk("full_hold_count", count_o, 4);
    ready_i = 1'b1;
    #1;
    chk("release_ready_pre", ready_o, 0);
    for (int k = 1; k <= 5; k++) begin
      data_i  = (k >= 4) ? 8'h15 : 8'h14;
      valid_i = (k <= 4);
      tick();
      chk("drain_valid", valid_o, 1);
      chk("drain_data", data_o, 8'h10 + 8'(k));
      if (k == 2) chk("drain_ready_e2", ready_o, 1);
    end
    valid_i = 1'b0;
    tick();
    chk("drain_done_valid", valid_o, 0);
    chk("drain_done_count", count_o, 0);

    // Flush while full; 0xAA offered during the flush is dropped
    ready_i = 1'b0; valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'h21 + 8'(i);
      tick();
    end
    chk("pre_flush_count", count_o, 4);
    flush = 1'b1; data_i = 8'hAA;
    #1;
    chk("flush_valid", valid_o, 0);
    chk("flush_ready", ready_o, 0);
    tick();
    flush = 1'b0; valid_i = 1'b0;
    #1;
    chk("post_flush_count", count_o, 0);
    chk("post_flush_valid", valid_o, 0);
    chk("post_flush_ready", ready_o, 1);
    ready_i = 1'b1; valid_i = 1'b1; data_i = 8'hBB;
    tick();
    valid_i = 1'b0;
    tick();
    chk("bb_valid", valid_o, 1);
    chk("bb_data", data_o, 8'hBB);
    tick();
    chk("bb_alone", valid_o, 0);

    // Random stalls on both sides
    sent = 0;
    for (int c = 0; c < 6000 && sent < 1000; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      data_i  = 8'($urandom);
      #1;
      if (valid_i && ready_o) sent++;
      tick();
    end
    chk("rand_sent", sent, 1000);
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (8) tick();
    chk("rand_drain_count", count_o, 0);
    chk("rand_drain_valid", valid_o, 0);

    // Reset together with flush and valid while three beats are stored
    ready_i = 1'b0; valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = 8'h31 + 8'(i);
      tick();
    end
    chk("mid_count", count_o, 3);
    rst = 1'b1; flush = 1'b1; ready_i = 1'b1; data_i = 8'h77;
    tick();
    rst = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    #1;
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    for (int i = 0; i < 6; i++) begin
      ready_i = ~ready_i;
      tick();
      chk("mid_rst_quiet", valid_o, 0);
    end

    // Bypass instance
    b_valid_i = 1'b1; b_data_i = 8'h5C; b_ready_i = 1'b1;
    #1;
    chk("byp_valid", b_valid_o, 1);
    chk("byp_data", b_data_o, 8'h5C);
    chk("byp_ready", b_ready_o, 1);
    chk("byp_count", b_count_o, 0);
    b_ready_i = 1'b0;
    #1;
    chk("byp_ready_low", b_ready_o, 0);
    b_ready_i = 1'b1; b_flush = 1'b1;
    #1;
    chk("byp_flush_valid", b_valid_o, 0);
    chk("byp_flush_ready", b_ready_o, 0);
    chk("byp_flush_count", b_count_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spill_register_pipe.md
Name: spill_register_pipe

Overview:
- Parametrised successor to the single-stage flushable spill register.
- Chains NumStages fully registered spill stages. Each stage has two slots and cuts both the valid/data path and the ready path.
- Adds a synchronous flush over all stages and a live occupancy count.
- Placed on long stream interconnect paths, such as crossbar ports and inter-cluster links, where several register cuts are needed with no throughput loss.

Parameters:
DataWidth, 32, payload width in bits (>=1)
NumStages, 2, number of chained spill stages (>=1); total capacity 2*NumStages
Bypass, 1'b0, 1 = whole block combinational pass-through (no registers)
CntWidth, $clog2(2*NumStages+1), width of count_o (derived, do not override)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous, active-high reset
flush_i  input  1  synchronous flush; discards all stored beats
valid_i  input  1  upstream beat valid
ready_o  output  1  upstream ready
data_i  input  DataWidth  upstream payload
valid_o  output  1  downstream beat valid
ready_i  input  1  downstream ready
data_o  output  DataWidth  downstream payload
count_o  output  CntWidth  number of beats currently stored (0..2*NumStages)

Behaviour:
- Handshake: a transfer occurs when valid and ready are both high on the same edge. Once valid_o is asserted, it stays high and data_o stays stable until ready_i is seen, unless flush_i or rst_i intervenes.
- Per-stage structure: slot A (input side) and slot B (overflow), each with a full flag.
  - Stage ready_out = !a_full | !b_full.
  - Stage valid_out = a_full | b_full.
  - Stage data_out = b_full ? b_data : a_data.
- Per-stage update on each clock edge:
  - a_fill = in_valid & ready_out.
  - a_drain = a_full & !b_full.
  - b_fill = a_drain & !out_ready.
  - b_drain = b_full & out_ready.
  - a_full' = a_fill | (a_full & !a_drain).
  - b_full' = b_fill | (b_full & !b_drain).
  - Data captured only on a_fill or b_fill.
- Chaining: stage k output feeds stage k+1 input. Stage 0 input is valid_i/data_i/ready_o; the last stage output is valid_o/data_o/ready_i.
- No combinational path exists from ready_i to ready_o, nor from valid_i/data_i to valid_o/data_o.
- Latency: empty pipe with ready_i=1 gives a beat accepted at edge t on valid_o in cycle t+NumStages−1 after that edge, i.e. NumStages edges of delay. Sustained throughput is 1 beat/cycle.
- Ordering: strict FIFO order. No beats are lost or duplicated except by flush/reset.
- Full: with ready_i=0, the block accepts 2*NumStages beats. ready_o then goes low the cycle after the last slot fills.
- count_o: registered total of set full flags.
  - Increments on an input transfer.
  - Decrements on an output transfer.
  - Unchanged when both happen in the same cycle.
  - Never exceeds 2*NumStages and never wraps.
- flush_i:
  - All full flags clear at the next edge, and count_o is 0 after that edge.
  - While flush_i=1, ready_o is forced to 0 (no input accepted) and valid_o is forced to 0 (no output beat).
  - A valid_i present in the flush cycle is not accepted and not stored.
  - Data registers need not clear.
- rst_i (synchronous, any time, including mid-stream or mid-flush): at the next edge all full flags clear. rst_i has priority over flush_i and over any fill.
- Reset values:
  - valid_o=0, count_o=0.
  - ready_o=1, provided flush_i=0.
  - data_o undefined (X tolerated), since data registers have no reset.
- Bypass=1:
  - valid_o=valid_i & !flush_i; ready_o=ready_i & !flush_i; data_o=data_i; count_o=0.
  - clk_i/rst_i unused.
- Assertions (simulation only):
  - DataWidth>=1 and NumStages>=1.
  - valid_o/data_o stable while valid_o & !ready_i & !flush_i & !rst_i.
  - count_o <= 2*NumStages.

Test Plan:
- Setup for all scenarios: DataWidth=8, NumStages=2.
- Reset, then stream: hold rst_i 2 cycles. Expect valid_o=0, ready_o=1, count_o=0. Drive 0x01..0x08 back-to-back with ready_i=1. Expect 0x01 on data_o 2 edges after acceptance, then one beat per cycle in order, and count_o steady at 2 during streaming.
- Backpressure to full: ready_i=0, drive 0x10..0x15. Expect 0x10..0x13 accepted, ready_o=0 after the 4th, count_o=4. Then set ready_i=1: expect 0x10,0x11,0x12,0x13,0x14,0x15 out in order with no bubbles after the first.
- Flush while full: fill 4 beats, assert flush_i for 1 cycle with valid_i=1, data 0xAA. Expect valid_o=0 and ready_o=0 during the flush cycle, count_o=0 after. 0xAA never appears; the next beat 0xBB emerges alone.
- Random stall on both sides: 1000 beats of random valid_i and ready_i. Expect the scoreboard to match exactly, count_o to equal the scoreboard occupancy every cycle, and the stability assertion never to fire.
- Reset mid-operation: with 3 beats stored and ready_i toggling, pulse rst_i together with flush_i=1 and valid_i=1. Expect count_o=0, valid_o=0, ready_o=1 next cycle (with flush_i released), and no stored beat ever output.
- Bypass=1, NumStages=1: drive valid_i=1, data 0x5C, ready_i=1. Expect the same-cycle valid_o=1, data_o=0x5C, ready_o=1. With flush_i=1, expect valid_o=0 and ready_o=0; count_o is always 0.
